// File: rtl/id_ex_if.sv
// ID/EX stage bundle: everything the ID/EX pipeline register exchanges with
// the surrounding core except the clock and reset.
//   master : upstream/core side (drives ID fields, stall/flush, forwarding
//            sources; observes hazard and the EX-stage outputs)
//   slave  : the id_ex_stage register itself
interface id_ex_if #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int OPW = 4
);
  // pipeline control
  logic           stall;
  logic           flush;
  // ID-stage fields
  logic [DW-1:0]  PC_in;
  logic [AW-1:0]  r1A;
  logic [AW-1:0]  r2A;
  logic [AW-1:0]  rdA;
  logic [DW-1:0]  reg1Data;
  logic [DW-1:0]  reg2Data;
  logic [15:0]    imm16;
  logic           signExt;
  logic           regW_in;
  logic           memR_in;
  logic           memW_in;
  logic           aluSrc_in;
  logic           regDst_in;
  logic [OPW-1:0] aluOp_in;
  // forwarding sources
  logic           exmem_regW;
  logic [AW-1:0]  exmem_wrA;
  logic [DW-1:0]  exmem_res;
  logic           memwb_regW;
  logic [AW-1:0]  memwb_wrA;
  logic [DW-1:0]  memwb_wrD;
  // EX-stage outputs
  logic           hazard;
  logic           valid;
  logic [DW-1:0]  PC_out;
  logic [DW-1:0]  imm_out;
  logic [DW-1:0]  opA;
  logic [DW-1:0]  opB;
  logic [1:0]     fwdA;
  logic [1:0]     fwdB;
  logic [AW-1:0]  wrA_out;
  logic           regW;
  logic           memR;
  logic           memW;
  logic           aluSrc;
  logic [OPW-1:0] aluOp;

  modport master (
    output stall, flush, PC_in, r1A, r2A, rdA, reg1Data, reg2Data, imm16,
           signExt, regW_in, memR_in, memW_in, aluSrc_in, regDst_in, aluOp_in,
           exmem_regW, exmem_wrA, exmem_res, memwb_regW, memwb_wrA, memwb_wrD,
    input  hazard, valid, PC_out, imm_out, opA, opB, fwdA, fwdB, wrA_out,
           regW, memR, memW, aluSrc, aluOp
  );

  modport slave (
    input  stall, flush, PC_in, r1A, r2A, rdA, reg1Data, reg2Data, imm16,
           signExt, regW_in, memR_in, memW_in, aluSrc_in, regDst_in, aluOp_in,
           exmem_regW, exmem_wrA, exmem_res, memwb_regW, memwb_wrA, memwb_wrD,
    output hazard, valid, PC_out, imm_out, opA, opB, fwdA, fwdB, wrA_out,
           regW, memR, memW, aluSrc, aluOp
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage MIPS core.
//   - Registers PC+4, register operands, extended immediate, destination and
//     decoded control each cycle (1-cycle latency).
//   - Detects load-use hazards combinationally and inserts one bubble.
//   - Drives forwarded EX operands: EX/MEM first, then MEM/WB, then the
//     registered register-file value. Register 0 is never forwarded.
// Ports:
//   clk  core clock, all state updates on posedge
//   rst  synchronous active-high reset, clears every register
//   bus  id_ex_if.slave: stall/flush, ID fields, forwarding sources,
//        hazard and all EX-stage outputs
// Update priority at posedge: rst > flush > stall > hazard > capture.
// Optional: define ID_EX_TRACE_EN to print a per-cycle trace line and keep a
// cycle counter (cleared by rst). Ports and timing do not change.
module id_ex_stage #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int OPW = 4
) (
  input logic   clk,
  input logic   rst,
  id_ex_if.slave bus
);

  function automatic logic [DW-1:0] ext_imm(input logic [15:0] imm, input logic sx);
    logic signed [15:0] simm;
    simm = imm;
    return sx ? {{(DW-16){simm[15]}}, imm} : {{(DW-16){1'b0}}, imm};
  endfunction

  // 2'b10 = EX/MEM, 2'b01 = MEM/WB, 2'b00 = registered value
  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src,
                                         input logic ex_w, input logic [AW-1:0] ex_a,
                                         input logic wb_w, input logic [AW-1:0] wb_a);
    if (ex_w && (ex_a != '0) && (ex_a == src))      return 2'b10;
    else if (wb_w && (wb_a != '0) && (wb_a == src)) return 2'b01;
    else                                            return 2'b00;
  endfunction

  logic           vld_p1;
  logic           regw_p1, memr_p1, memw_p1, alusrc_p1;
  logic [OPW-1:0] aluop_p1;
  logic [DW-1:0]  pc_p1, imm_p1, a_p1, b_p1;
  logic [AW-1:0]  wra_p1, rs_p1, rt_p1;

  logic           hazard_c;
  logic [1:0]     fwda_c, fwdb_c;

  // A load in EX whose destination is read by the instruction in ID
  assign hazard_c = vld_p1 && memr_p1 && (wra_p1 != '0) &&
                    ((wra_p1 == bus.r1A) || (wra_p1 == bus.r2A));

  // ---- ID -> EX register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      regw_p1   <= 1'b0;
      memr_p1   <= 1'b0;
      memw_p1   <= 1'b0;
      alusrc_p1 <= 1'b0;
      aluop_p1  <= '0;
      pc_p1     <= '0;
      imm_p1    <= '0;
      a_p1      <= '0;
      b_p1      <= '0;
      wra_p1    <= '0;
      rs_p1     <= '0;
      rt_p1     <= '0;
    end else if (bus.flush || (!bus.stall && hazard_c)) begin
      // Bubble: only control is cleared, datapath registers keep stale values
      vld_p1    <= 1'b0;
      regw_p1   <= 1'b0;
      memr_p1   <= 1'b0;
      memw_p1   <= 1'b0;
      alusrc_p1 <= 1'b0;
      aluop_p1  <= '0;
    end else if (!bus.stall) begin
      vld_p1    <= 1'b1;
      regw_p1   <= bus.regW_in;
      memr_p1   <= bus.memR_in;
      memw_p1   <= bus.memW_in;
      alusrc_p1 <= bus.aluSrc_in;
      aluop_p1  <= bus.aluOp_in;
      pc_p1     <= bus.PC_in;
      imm_p1    <= ext_imm(bus.imm16, bus.signExt);
      a_p1      <= bus.reg1Data;
      b_p1      <= bus.reg2Data;
      wra_p1    <= bus.regDst_in ? bus.rdA : bus.r2A;
      rs_p1     <= bus.r1A;
      rt_p1     <= bus.r2A;
    end
  end

  // ---- EX operand forwarding (combinational on registered state) ----
  assign fwda_c = fwd_sel(rs_p1, bus.exmem_regW, bus.exmem_wrA, bus.memwb_regW, bus.memwb_wrA);
  assign fwdb_c = fwd_sel(rt_p1, bus.exmem_regW, bus.exmem_wrA, bus.memwb_regW, bus.memwb_wrA);

  always_comb begin
    bus.opA = a_p1;
    bus.opB = b_p1;
    if (fwda_c == 2'b10)      bus.opA = bus.exmem_res;
    else if (fwda_c == 2'b01) bus.opA = bus.memwb_wrD;
    if (fwdb_c == 2'b10)      bus.opB = bus.exmem_res;
    else if (fwdb_c == 2'b01) bus.opB = bus.memwb_wrD;
  end

  assign bus.hazard  = hazard_c;
  assign bus.valid   = vld_p1;
  assign bus.PC_out  = pc_p1;
  assign bus.imm_out = imm_p1;
  assign bus.fwdA    = fwda_c;
  assign bus.fwdB    = fwdb_c;
  assign bus.wrA_out = wra_p1;
  assign bus.regW    = regw_p1;
  assign bus.memR    = memr_p1;
  assign bus.memW    = memw_p1;
  assign bus.aluSrc  = alusrc_p1;
  assign bus.aluOp   = aluop_p1;

`ifdef ID_EX_TRACE_EN
  integer cyc;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc <= 0;
    end else begin
      cyc <= cyc + 1;
      if (bus.flush || (!bus.stall && hazard_c))
        $display("[ID/EX] cyc=%0d bubble", cyc);
      else if (!bus.stall)
        $display("[ID/EX] cyc=%0d PC=%h rs=%0d rt=%0d A=%h B=%h",
                 cyc, bus.PC_in, bus.r1A, bus.r2A, bus.reg1Data, bus.reg2Data);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  id_ex_if #(.DW(32), .AW(5), .OPW(4)) bus ();

  id_ex_stage #(.DW(32), .AW(5), .OPW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference view of the instruction sitting in EX. dpk says whether the
  // datapath fields are defined (they are not after a bubble).
  typedef struct {
    bit        valid, regw, memr, memw, alusrc, dpk;
    bit [3:0]  aluop;
    bit [31:0] pc, imm, a, b;
    bit [4:0]  wra, rs, rt;
  } ex_t;

  ex_t m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_hazard();
    return m.valid && m.memr && m.wra != 0 && (m.wra == bus.r1A || m.wra == bus.r2A);
  endfunction

  // Newest producer wins; $zero is hardwired and never forwarded.
  task automatic ref_operand(input bit [4:0] src, input bit [31:0] regval,
                             output bit [31:0] val, output bit [1:0] sel);
    if (bus.exmem_regW && bus.exmem_wrA == src && src != 0) begin
      val = bus.exmem_res; sel = 2'b10;
    end else if (bus.memwb_regW && bus.memwb_wrA == src && src != 0) begin
      val = bus.memwb_wrD; sel = 2'b01;
    end else begin
      val = regval; sel = 2'b00;
    end
  endtask

  task automatic check_all();
    bit [31:0] va, vb;
    bit [1:0]  sa, sb;
    chk("valid",  bus.valid,  m.valid);
    chk("regW",   bus.regW,   m.regw);
    chk("memR",   bus.memR,   m.memr);
    chk("memW",   bus.memW,   m.memw);
    chk("aluOp",  bus.aluOp,  m.aluop);
    chk("hazard", bus.hazard, ref_hazard());
    if (m.dpk) begin
      ref_operand(m.rs, m.a, va, sa);
      ref_operand(m.rt, m.b, vb, sb);
      chk("PC_out",  bus.PC_out,  m.pc);
      chk("imm_out", bus.imm_out, m.imm);
      chk("wrA_out", bus.wrA_out, m.wra);
      chk("aluSrc",  bus.aluSrc,  m.alusrc);
      chk("opA",     bus.opA,     va);
      chk("opB",     bus.opB,     vb);
      chk("fwdA",    bus.fwdA,    sa);
      chk("fwdB",    bus.fwdB,    sb);
    end
  endtask

  // One clock: predict the next EX contents from the inputs presented now,
  // then compare everything just after the edge.
  task automatic tick();
    ex_t n;
    n = m;
    if (rst) begin
      n = '{default: 0};
      n.dpk = 1'b1;
    end else if (bus.flush || (!bus.stall && ref_hazard())) begin
      n.valid = 0; n.regw = 0; n.memr = 0; n.memw = 0; n.aluop = 0; n.dpk = 0;
    end else if (!bus.stall) begin
      n.valid  = 1;
      n.dpk    = 1;
      n.regw   = bus.regW_in;
      n.memr   = bus.memR_in;
      n.memw   = bus.memW_in;
      n.alusrc = bus.aluSrc_in;
      n.aluop  = bus.aluOp_in;
      n.pc     = bus.PC_in;
      n.imm    = bus.signExt ? 32'(signed'(bus.imm16)) : 32'(bus.imm16);
      n.a      = bus.reg1Data;
      n.b      = bus.reg2Data;
      n.wra    = bus.regDst_in ? bus.rdA : bus.r2A;
      n.rs     = bus.r1A;
      n.rt     = bus.r2A;
    end
    @(posedge clk);
    #1;
    m = n;
    check_all();
  endtask

  task automatic rand_id();
    bus.PC_in      = $urandom;
    bus.r1A        = 5'($urandom_range(0, 3));
    bus.r2A        = 5'($urandom_range(0, 3));
    bus.rdA        = 5'($urandom_range(0, 3));
    bus.reg1Data   = $urandom;
    bus.reg2Data   = $urandom;
    bus.imm16      = 16'($urandom);
    bus.signExt    = 1'($urandom);
    bus.regW_in    = 1'($urandom);
    bus.memR_in    = ($urandom_range(0, 2) == 0);
    bus.memW_in    = 1'($urandom);
    bus.aluSrc_in  = 1'($urandom);
    bus.regDst_in  = 1'($urandom);
    bus.aluOp_in   = 4'($urandom);
    bus.exmem_regW = 1'($urandom);
    bus.exmem_wrA  = 5'($urandom_range(0, 3));
    bus.exmem_res  = $urandom;
    bus.memwb_regW = 1'($urandom);
    bus.memwb_wrA  = 5'($urandom_range(0, 3));
    bus.memwb_wrD  = $urandom;
  endtask

  task automatic clear_in();
    bus.stall = 0; bus.flush = 0;
    bus.PC_in = 0; bus.r1A = 0; bus.r2A = 0; bus.rdA = 0;
    bus.reg1Data = 0; bus.reg2Data = 0; bus.imm16 = 0; bus.signExt = 0;
    bus.regW_in = 0; bus.memR_in = 0; bus.memW_in = 0; bus.aluSrc_in = 0;
    bus.regDst_in = 0; bus.aluOp_in = 0;
    bus.exmem_regW = 0; bus.exmem_wrA = 0; bus.exmem_res = 0;
    bus.memwb_regW = 0; bus.memwb_wrA = 0; bus.memwb_wrD = 0;
  endtask

  initial begin
    m = '{default: 0};
    clear_in();

    // Reset with random inputs
    rst = 1;
    rand_id(); bus.stall = 1'($urandom); bus.flush = 1'($urandom);
    tick();
    rand_id(); bus.stall = 1'($urandom); bus.flush = 1'($urandom);
    tick();
    chk("rst_valid",  bus.valid,   0);
    chk("rst_hazard", bus.hazard,  0);
    chk("rst_pc",     bus.PC_out,  0);
    chk("rst_imm",    bus.imm_out, 0);
    chk("rst_opA",    bus.opA,     0);
    chk("rst_opB",    bus.opB,     0);
    chk("rst_wrA",    bus.wrA_out, 0);

    // Basic capture with sign-extended immediate
    rst = 0;
    clear_in();
    bus.r1A = 3; bus.reg1Data = 5; bus.imm16 = 16'hFFFC; bus.signExt = 1;
    tick();
    chk("cap_opA",   bus.opA,     32'd5);
    chk("cap_imm",   bus.imm_out, 32'hFFFF_FFFC);
    chk("cap_valid", bus.valid,   1);
    chk("cap_fwdA",  bus.fwdA,    2'b00);

    // Load-use: lw into $8, followed by a reader of $8
    clear_in();
    bus.r2A = 8; bus.regDst_in = 0; bus.memR_in = 1; bus.regW_in = 1;
    tick();
    clear_in();
    bus.r1A = 8; bus.r2A = 1; bus.reg1Data = 32'h777;
    #1;
    chk("lu_hazard", bus.hazard, 1);
    tick();
    chk("lu_bubble_valid", bus.valid,  0);
    chk("lu_bubble_regW",  bus.regW,   0);
    chk("lu_hazard_drop",  bus.hazard, 0);
    bus.memwb_regW = 1; bus.memwb_wrA = 8; bus.memwb_wrD = 32'h1234;
    tick();
    chk("lu_fwdA", bus.fwdA, 2'b01);
    chk("lu_opA",  bus.opA,  32'h1234);

    // Forwarding priority and the $zero rule
    clear_in();
    bus.r1A = 9; bus.r2A = 9; bus.reg1Data = 32'h55; bus.reg2Data = 32'h56;
    tick();
    bus.exmem_regW = 1; bus.exmem_wrA = 9; bus.exmem_res = 32'hAA;
    bus.memwb_regW = 1; bus.memwb_wrA = 9; bus.memwb_wrD = 32'hBB;
    #1;
    chk("fw_ex_opA",  bus.opA,  32'hAA);
    chk("fw_ex_fwdA", bus.fwdA, 2'b10);
    chk("fw_ex_opB",  bus.opB,  32'hAA);
    chk("fw_ex_fwdB", bus.fwdB, 2'b10);
    bus.exmem_wrA = 0;
    #1;
    chk("fw_wb_opA",  bus.opA,  32'hBB);
    chk("fw_wb_fwdA", bus.fwdA, 2'b01);
    bus.memwb_wrA = 0;
    #1;
    chk("fw_none_opA",  bus.opA,  32'h55);
    chk("fw_none_fwdA", bus.fwdA, 2'b00);
    bus.r1A = 0; bus.r2A = 0; bus.reg1Data = 32'h66;
    tick();
    chk("fw_r0_opA",  bus.opA,  32'h66);
    chk("fw_r0_fwdA", bus.fwdA, 2'b00);

    // Stall freezes, flush wins over stall
    clear_in();
    bus.PC_in = 32'h100; bus.memW_in = 1; bus.r1A = 4; bus.r2A = 5;
    tick();
    for (int i = 0; i < 3; i++) begin
      rand_id();
      bus.stall = 1;
      tick();
      chk("stall_pc",   bus.PC_out, 32'h100);
      chk("stall_memW", bus.memW,   1);
    end
    bus.flush = 1; bus.stall = 1;
    tick();
    chk("flush_valid", bus.valid, 0);
    chk("flush_memW",  bus.memW,  0);

    // Reset during a stalled load-use: next cycle is a normal capture
    clear_in();
    bus.r2A = 2; bus.memR_in = 1; bus.regW_in = 1;
    tick();
    clear_in();
    bus.r1A = 2; bus.stall = 1; rst = 1;
    #1;
    chk("rh_hazard", bus.hazard, 1);
    tick();
    chk("rh_valid", bus.valid, 0);
    rst = 0; bus.stall = 0;
    tick();
    chk("rh_capture", bus.valid, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_id();
      bus.stall = ($urandom_range(0, 5) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 39) == 0);
      tick();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
